// File: rtl/ctl_panel_pkg.sv
// Shared types and constants for the user-side panel controller.
// Holds panel states, program-set codes, water limits and the mode stepper.
package ctl_panel_pkg;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_SETUP,
        ST_START,
        ST_RUN,
        ST_PAUSE,
        ST_FINISH
    } state_t;

    // Program-set codes: bit0 wash, bit1 rinse, bit2 dry
    localparam logic [2:0] MD_WRD = 3'b111;
    localparam logic [2:0] MD_W   = 3'b001;
    localparam logic [2:0] MD_WR  = 3'b011;
    localparam logic [2:0] MD_R   = 3'b010;
    localparam logic [2:0] MD_RD  = 3'b110;
    localparam logic [2:0] MD_D   = 3'b100;

    localparam logic [5:0] WAT_MIN = 6'd3;
    localparam logic [5:0] WAT_MAX = 6'd8;
    localparam logic [5:0] WAT_DEF = 6'd5;

    // Program-set ring: WRD -> W -> WR -> R -> RD -> D -> WRD
    function automatic logic [2:0] next_mode(input logic [2:0] m);
        logic [2:0] n;
        case (m)
            MD_WRD:  n = MD_W;
            MD_W:    n = MD_WR;
            MD_WR:   n = MD_R;
            MD_R:    n = MD_RD;
            MD_RD:   n = MD_D;
            default: n = MD_WRD;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ctl_panel_idle_tmr.sv
// Idle auto-off timer: counts enabled, uncleared cycles and flags the last one.
// Ports: clk, rst_n, en (count), clr (restart), expired (CMAX-th idle cycle).
module idle_tmr
    import ctl_panel_pkg::*;
#(
    parameter int unsigned CMAX = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int W = $clog2(CMAX + 1);
    localparam logic [W-1:0] LAST = W'(CMAX - 1);

    logic [W-1:0] cnt;

    // Fires during the CMAX-th consecutive idle cycle so the owner leaves
    // the idle state exactly CMAX cycles after entry or the last press.
    assign expired = en && !clr && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != LAST) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/ctl_panel.sv
// User-side controller for run_mode: power, program/water setup, start/pause.
// Ports: clk, rst_n, btn_pow/ss/mode/wat pulses, run_done -> init, u_wat, clr, pau, pow, fin.
module ctl_panel
    import ctl_panel_pkg::*;
#(
    parameter int unsigned TIM_CMAX = 50_000_000,
    parameter int unsigned IDLE_SEC = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_pow,
    input  logic       btn_ss,
    input  logic       btn_mode,
    input  logic       btn_wat,
    input  logic       run_done,
    output logic [2:0] init,
    output logic [5:0] u_wat,
    output logic       clr,
    output logic       pau,
    output logic       pow,
    output logic       fin
);

    state_t     st_q;
    state_t     st_d;
    logic [2:0] init_d;
    logic [5:0] wat_d;
    logic       skip_q;
    logic       any_btn;
    logic       tmr_en;
    logic       tmr_clr;
    logic       expired;

    assign any_btn = btn_pow | btn_ss | btn_mode | btn_wat;
    assign tmr_en  = (st_q == ST_SETUP) || (st_q == ST_FINISH);
    assign tmr_clr = !tmr_en || any_btn;

    idle_tmr #(
        .CMAX (IDLE_SEC * TIM_CMAX)
    ) u_idle (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (tmr_en),
        .clr     (tmr_clr),
        .expired (expired)
    );

    always_comb begin
        st_d   = st_q;
        init_d = init;
        wat_d  = u_wat;
        case (st_q)
            ST_OFF: begin
                if (btn_pow) begin
                    st_d   = ST_SETUP;
                    init_d = MD_WRD;
                    wat_d  = WAT_DEF;
                end
            end
            ST_SETUP: begin
                if (btn_pow) begin
                    st_d = ST_OFF;
                end else if (btn_ss) begin
                    st_d = ST_START;
                end else if (btn_mode) begin
                    init_d = next_mode(init);
                end else if (btn_wat) begin
                    wat_d = (u_wat >= WAT_MAX) ? WAT_MIN : u_wat + 6'd1;
                end else if (expired) begin
                    st_d = ST_OFF;
                end
            end
            ST_START: begin
                st_d = btn_pow ? ST_OFF : ST_RUN;
            end
            ST_RUN: begin
                // skip_q masks a stale done from the previous run
                if (btn_pow) begin
                    st_d = ST_OFF;
                end else if (run_done && !skip_q) begin
                    st_d = ST_FINISH;
                end else if (btn_ss) begin
                    st_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (btn_pow) begin
                    st_d = ST_OFF;
                end else if (btn_ss) begin
                    st_d = ST_RUN;
                end
            end
            ST_FINISH: begin
                if (btn_pow) begin
                    st_d = ST_OFF;
                end else if (btn_ss || btn_mode || btn_wat) begin
                    st_d = ST_SETUP;
                end else if (expired) begin
                    st_d = ST_OFF;
                end
            end
            default: st_d = ST_OFF;
        endcase
    end

    // Outputs are registered from the next state so they align with st_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_OFF;
            init   <= MD_WRD;
            u_wat  <= WAT_DEF;
            clr    <= 1'b0;
            pau    <= 1'b1;
            pow    <= 1'b0;
            fin    <= 1'b0;
            skip_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            init   <= init_d;
            u_wat  <= wat_d;
            clr    <= (st_d == ST_START);
            pau    <= !((st_d == ST_START) || (st_d == ST_RUN));
            pow    <= (st_d != ST_OFF);
            fin    <= (st_d == ST_FINISH);
            skip_q <= (st_q == ST_START) && (st_d == ST_RUN);
        end
    end

endmodule

// File: tb/tb_ctl_panel.sv
// Scoreboard bench for ctl_panel: behavioural model pushes expectations,
// a monitor pops and compares each cycle; directed then random stimulus.
module tb_ctl_panel;

    localparam int TC   = 4;
    localparam int IS   = 2;
    localparam int IDLE = TC * IS;

    logic       clk;
    logic       rst_n;
    logic       btn_pow;
    logic       btn_ss;
    logic       btn_mode;
    logic       btn_wat;
    logic       run_done;
    logic [2:0] init;
    logic [5:0] u_wat;
    logic       clr;
    logic       pau;
    logic       pow;
    logic       fin;

    ctl_panel #(
        .TIM_CMAX (TC),
        .IDLE_SEC (IS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_pow  (btn_pow),
        .btn_ss   (btn_ss),
        .btn_mode (btn_mode),
        .btn_wat  (btn_wat),
        .run_done (run_done),
        .init     (init),
        .u_wat    (u_wat),
        .clr      (clr),
        .pau      (pau),
        .pow      (pow),
        .fin      (fin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int i;
        int w;
        int c;
        int p;
        int o;
        int f;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Behavioural model: named phase, index into the program ring,
    // plain integer water level and idle-cycle count.
    string m_ph;
    int    m_idx;
    int    m_wat;
    int    m_idle;
    bit    m_first;
    int    ring[6] = '{7, 1, 3, 2, 6, 4};

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph    = "OFF";
        m_idx   = 0;
        m_wat   = 5;
        m_idle  = 0;
        m_first = 0;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.i = ring[m_idx];
        e.w = m_wat;
        e.c = (m_ph == "START") ? 1 : 0;
        e.p = (m_ph == "START" || m_ph == "RUN") ? 0 : 1;
        e.o = (m_ph == "OFF") ? 0 : 1;
        e.f = (m_ph == "FINISH") ? 1 : 0;
        return e;
    endfunction

    task automatic model_step(bit p, bit s, bit m, bit w, bit d);
        if (m_ph == "OFF") begin
            if (p) begin
                m_ph   = "SETUP";
                m_idx  = 0;
                m_wat  = 5;
                m_idle = 0;
            end
        end else if (p) begin
            m_ph = "OFF";
        end else if (m_ph == "SETUP") begin
            if (s) m_ph = "START";
            else if (m) m_idx = (m_idx + 1) % 6;
            else if (w) m_wat = (m_wat == 8) ? 3 : m_wat + 1;
            if (s || m || w) m_idle = 0;
            else begin
                m_idle++;
                if (m_idle >= IDLE) m_ph = "OFF";
            end
        end else if (m_ph == "START") begin
            m_ph    = "RUN";
            m_first = 1;
        end else if (m_ph == "RUN") begin
            if (d && !m_first) begin
                m_ph   = "FINISH";
                m_idle = 0;
            end else if (s) begin
                m_ph = "PAUSE";
            end
            m_first = 0;
        end else if (m_ph == "PAUSE") begin
            if (s) m_ph = "RUN";
        end else if (m_ph == "FINISH") begin
            if (s || m || w) begin
                m_ph   = "SETUP";
                m_idle = 0;
            end else begin
                m_idle++;
                if (m_idle >= IDLE) m_ph = "OFF";
            end
        end
    endtask

    // One clock of stimulus; expectation queued before the sampling edge
    task automatic step(bit p, bit s, bit m, bit w, bit d);
        @(negedge clk);
        btn_pow  = p;
        btn_ss   = s;
        btn_mode = m;
        btn_wat  = w;
        run_done = d;
        model_step(p, s, m, w, d);
        q.push_back(model_out());
        @(posedge clk);
        #1;
        btn_pow  = 0;
        btn_ss   = 0;
        btn_mode = 0;
        btn_wat  = 0;
        run_done = 0;
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("mon_init", int'(init), e.i);
            chk("mon_u_wat", int'(u_wat), e.w);
            chk("mon_clr", int'(clr), e.c);
            chk("mon_pau", int'(pau), e.p);
            chk("mon_pow", int'(pow), e.o);
            chk("mon_fin", int'(fin), e.f);
        end
    end

    initial begin
        rst_n    = 0;
        btn_pow  = 0;
        btn_ss   = 0;
        btn_mode = 0;
        btn_wat  = 0;
        run_done = 0;
        model_reset();
        #12;
        chk("rst_init", int'(init), 7);
        chk("rst_u_wat", int'(u_wat), 5);
        chk("rst_pau", int'(pau), 1);
        chk("rst_clr", int'(clr), 0);
        chk("rst_pow", int'(pow), 0);
        @(negedge clk);
        rst_n = 1;

        step(1, 0, 0, 0, 0);
        chk("pow_on", int'(pow), 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("mode_x2", int'(init), 3);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 0);
        chk("wat_wrap", int'(u_wat), 3);
        step(0, 1, 0, 0, 0);
        chk("start_clr", int'(clr), 1);
        chk("start_pau", int'(pau), 0);
        idle(1);
        chk("run_clr", int'(clr), 0);
        step(0, 1, 0, 0, 0);
        chk("pause_pau", int'(pau), 1);
        step(0, 1, 0, 0, 0);
        chk("resume_pau", int'(pau), 0);
        chk("resume_noclr", int'(clr), 0);
        idle(2);
        step(0, 0, 0, 0, 1);
        chk("done_fin", int'(fin), 1);

        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        idle(2);
        step(0, 1, 0, 0, 1);
        chk("ss_done_fin", int'(fin), 1);

        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("early_done_fin", int'(fin), 0);
        chk("early_done_pau", int'(pau), 0);
        step(0, 0, 0, 0, 1);
        chk("late_done_fin", int'(fin), 1);

        step(0, 0, 1, 0, 0);
        idle(6);
        step(0, 0, 0, 1, 0);
        idle(IDLE - 1);
        chk("idle_restart", int'(pow), 1);
        idle(1);
        chk("idle_off", int'(pow), 0);

        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        idle(2);
        step(1, 0, 0, 0, 0);
        chk("run_off_pow", int'(pow), 0);
        chk("run_off_pau", int'(pau), 1);
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("restart_clr", int'(clr), 1);
        idle(1);
        step(0, 1, 0, 0, 0);

        @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("arst_init", int'(init), 7);
        chk("arst_u_wat", int'(u_wat), 5);
        chk("arst_pau", int'(pau), 1);
        chk("arst_pow", int'(pow), 0);
        chk("arst_fin", int'(fin), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;

        for (int n = 0; n < 800; n++) begin
            if (n % 100 == 50) idle(IDLE + 1);
            step($urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 6) == 0);
        end

        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
